// File: rtl/sw_debounce_sb_ctrl.sv
// ---------------------------------------------------------------------------
// sw_debounce_sb_ctrl
//
// Switch-input peripheral for the system bus. Each of the SW_WIDTH raw switch
// lines is brought into the clk_i domain through a two-flop synchroniser and
// then debounced. A debounced bit changes only after the synchronised input
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles. Every change
// of a debounced bit latches a per-bit change flag. A maskable, registered
// level interrupt request is raised from those flags. The interrupt
// controller's return pulse clears every flag whose mask bit is set.
//
// Register map (byte offset = addr_i[7:0]):
//   0x00 VALUE  RO   debounced switch levels, zero-extended
//   0x04 FLAGS  R/W1C change flags
//   0x08 MASK   RW   interrupt mask
//   0x0C EDGE   RW   edge select (only with SW_SB_EDGE_SEL_EN defined)
//   0x24 RESET  WO   writing 1 performs a soft reset; reads return 0
//
// Optional feature macro: SW_SB_EDGE_SEL_EN
//   When defined, EDGE[i] = 1 lets only rising transitions of the debounced
//   bit set flags[i]. When EDGE[i] = 0, both directions set it. When the macro
//   is undefined, 0x0C behaves like an unmapped offset.
//
// Ports:
//   clk_i               system clock, rising edge
//   rst_i               synchronous active-high reset
//   req_i               bus request (already decoded for this peripheral)
//   WE_i                1 = write, 0 = read
//   addr_i              byte address, only [7:0] decoded
//   WD_i                write data
//   RD_o                registered read data
//   sw_i                raw asynchronous switch levels
//   interrupt_request_o level interrupt request
//   interrupt_return_i  one-cycle pulse when the handler returns
// ---------------------------------------------------------------------------
module sw_debounce_sb_ctrl #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                WE_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         WD_i,
  output logic [31:0]         RD_o,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                interrupt_request_o,
  input  logic                interrupt_return_i
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0] OFS_VALUE = 8'h00;
  localparam logic [7:0] OFS_FLAGS = 8'h04;
  localparam logic [7:0] OFS_MASK  = 8'h08;
  localparam logic [7:0] OFS_EDGE  = 8'h0C;
  localparam logic [7:0] OFS_RESET = 8'h24;

  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;
  logic [SW_WIDTH-1:0] stable;
  logic [SW_WIDTH-1:0] flags;
  logic [SW_WIDTH-1:0] mask;
  logic [CW-1:0]       cnt [SW_WIDTH];

  logic [SW_WIDTH-1:0] toggle;
  logic [SW_WIDTH-1:0] flag_set;
  logic [SW_WIDTH-1:0] flag_clr;
  logic [SW_WIDTH-1:0] wr_data;
  logic [7:0]          offset;
  logic                rd_en;
  logic                wr_en;
  logic                soft_rst;
  logic [31:0]         rd_value;
  logic                unused_addr;

  assign offset      = addr_i[7:0];
  assign wr_data     = WD_i[SW_WIDTH-1:0];
  assign rd_en       = req_i && !WE_i;
  assign wr_en       = req_i && WE_i;
  assign soft_rst    = wr_en && (offset == OFS_RESET) && (WD_i == 32'd1);
  assign unused_addr = ^addr_i[31:8];

  // A debounced bit flips on the edge where its counter has already reached
  // the last count and the synchronised input still disagrees with it.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      toggle[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

`ifdef SW_SB_EDGE_SEL_EN
  logic [SW_WIDTH-1:0] edge_sel;

  // Edge-selected bits only flag rising transitions. A toggling bit that is
  // currently 0 is about to rise.
  assign flag_set = toggle & (~edge_sel | ~stable);

  // The edge-select register shares the reset and write timing of MASK.
  always_ff @(posedge clk_i) begin
    if (rst_i || soft_rst) begin
      edge_sel <= '0;
    end else if (wr_en && (offset == OFS_EDGE)) begin
      edge_sel <= wr_data;
    end
  end
`else
  assign flag_set = toggle;
`endif

  // Flags are cleared by a W1C write to FLAGS and by the interrupt return.
  // The return uses the mask register as it stands before any write in the
  // same cycle.
  always_comb begin
    flag_clr = '0;
    if (wr_en && (offset == OFS_FLAGS)) begin
      flag_clr = flag_clr | wr_data;
    end
    if (interrupt_return_i) begin
      flag_clr = flag_clr | mask;
    end
  end

  // Read multiplexer. Unmapped offsets, including RESET, read as zero.
  always_comb begin
    rd_value = 32'd0;
    case (offset)
      OFS_VALUE: rd_value = 32'(stable);
      OFS_FLAGS: rd_value = 32'(flags);
      OFS_MASK:  rd_value = 32'(mask);
`ifdef SW_SB_EDGE_SEL_EN
      OFS_EDGE:  rd_value = 32'(edge_sel);
`endif
      default:   rd_value = 32'd0;
    endcase
  end

  // Main state: the synchroniser, debounce counters, stable levels, flags,
  // mask, read data and interrupt request. A hard or soft reset returns all
  // of it to zero. Because the synchroniser also clears, switches held high
  // through reset are debounced again from scratch.
  always_ff @(posedge clk_i) begin
    if (rst_i || soft_rst) begin
      sync1               <= '0;
      sync2               <= '0;
      stable              <= '0;
      flags               <= '0;
      mask                <= '0;
      RD_o                <= 32'd0;
      interrupt_request_o <= 1'b0;
      for (int i = 0; i < SW_WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= sw_i;
      sync2  <= sync1;
      stable <= stable ^ toggle;
      for (int i = 0; i < SW_WIDTH; i++) begin
        if ((sync2[i] == stable[i]) || toggle[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      // A flag set in the same cycle as a clear wins.
      flags <= (flags & ~flag_clr) | flag_set;
      if (wr_en && (offset == OFS_MASK)) begin
        mask <= wr_data;
      end
      if (rd_en) begin
        RD_o <= rd_value;
      end
      interrupt_request_o <= |(flags & mask);
    end
  end

endmodule

// File: tb/tb_sw_debounce_sb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce_sb_ctrl
//
// Self-checking bench for sw_debounce_sb_ctrl with SW_WIDTH=16 and
// DEBOUNCE_CYCLES=4. Each bus read pushes its expected value onto a queue.
// The value is popped and compared once RD_o has been loaded one edge later.
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point.
// ---------------------------------------------------------------------------
module tb_sw_debounce_sb_ctrl;

  localparam int SW_WIDTH = 16;
  localparam int DEB      = 4;

  localparam logic [31:0] A_VALUE = 32'h00;
  localparam logic [31:0] A_FLAGS = 32'h04;
  localparam logic [31:0] A_MASK  = 32'h08;
  localparam logic [31:0] A_EDGE  = 32'h0C;
  localparam logic [31:0] A_RESET = 32'h24;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                req_i = 1'b0;
  logic                WE_i  = 1'b0;
  logic [31:0]         addr_i = '0;
  logic [31:0]         WD_i = '0;
  logic [31:0]         RD_o;
  logic [SW_WIDTH-1:0] sw_i = '0;
  logic                interrupt_request_o;
  logic                interrupt_return_i = 1'b0;

  int testsRun  = 0;
  int testsFail = 0;

  logic [31:0] expQ [$];
  string       tagQ [$];

  sw_debounce_sb_ctrl #(
    .SW_WIDTH(SW_WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .WE_i(WE_i),
    .addr_i(addr_i),
    .WD_i(WD_i),
    .RD_o(RD_o),
    .sw_i(sw_i),
    .interrupt_request_o(interrupt_request_o),
    .interrupt_return_i(interrupt_return_i)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk_i = ~clk_i;

  // Safety net so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Issue a one-cycle read. The expected value goes on the scoreboard now
  // and is compared once RD_o has loaded on the following edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expected,
                               input string tag);
    req_i  = 1'b1;
    WE_i   = 1'b0;
    addr_i = addr;
    expQ.push_back(expected);
    tagQ.push_back(tag);
    tick();
    req_i = 1'b0;
    checkOutput(tagQ.pop_front(), RD_o, expQ.pop_front());
  endtask

  // One-cycle bus write.
  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    req_i  = 1'b1;
    WE_i   = 1'b1;
    addr_i = addr;
    WD_i   = data;
    tick();
    req_i = 1'b0;
    WE_i  = 1'b0;
    WD_i  = '0;
  endtask

  initial begin
    idle(2);
    rst_i = 1'b0;

    // Reset state.
    applyStimulus(A_VALUE, 32'h0, "reset_value");
    checkOutput("reset_irq", {31'd0, interrupt_request_o}, 32'd0);
    applyStimulus(A_FLAGS, 32'h0, "reset_flags");
    applyStimulus(A_MASK,  32'h0, "reset_mask");

    // A 3-cycle glitch on bit 0 is one cycle too short to pass the debouncer.
    sw_i = 16'h0001;
    idle(3);
    sw_i = 16'h0000;
    idle(8);
    applyStimulus(A_VALUE, 32'h0, "glitch_value");
    applyStimulus(A_FLAGS, 32'h0, "glitch_flags");

    // Stable value updates on the 6th edge after the change. A read sampled
    // on that edge still sees the old value; the next read sees the new one.
    sw_i = 16'h00A5;
    idle(4);
    applyStimulus(A_VALUE, 32'h0,  "value_edge5");
    applyStimulus(A_VALUE, 32'h0,  "value_edge6_preupdate");
    applyStimulus(A_VALUE, 32'hA5, "value_edge7");
    applyStimulus(A_FLAGS, 32'hA5, "flags_after_a5");
    checkOutput("irq_masked_off", {31'd0, interrupt_request_o}, 32'd0);

    // Prepare bit 0 low with clean flags, then unmask bit 0 only.
    sw_i = 16'h00A4;
    idle(8);
    writeReg(A_FLAGS, 32'hFFFF);
    writeReg(A_MASK,  32'h0001);
    applyStimulus(A_FLAGS, 32'h0, "flags_cleared");

    // Bit 0 rises and bit 2 falls together. Flags set on edge 6 and the
    // interrupt follows one edge later.
    sw_i = 16'h00A1;
    idle(6);
    checkOutput("irq_not_yet", {31'd0, interrupt_request_o}, 32'd0);
    tick();
    checkOutput("irq_raised", {31'd0, interrupt_request_o}, 32'd1);
    applyStimulus(A_FLAGS, 32'h5, "flags_bit0_bit2");

    // Interrupt return clears only masked flags; the request drops one edge
    // after the flag.
    interrupt_return_i = 1'b1;
    tick();
    interrupt_return_i = 1'b0;
    checkOutput("irq_held_one_cycle", {31'd0, interrupt_request_o}, 32'd1);
    tick();
    checkOutput("irq_dropped", {31'd0, interrupt_request_o}, 32'd0);
    applyStimulus(A_FLAGS, 32'h4, "flags_after_return");

    // W1C of bit 2 on the same edge that bit 2 sets again: set wins.
    writeReg(A_FLAGS, 32'hFFFF);
    sw_i = 16'h00A5;
    idle(5);
    writeReg(A_FLAGS, 32'h0004);
    applyStimulus(A_FLAGS, 32'h4, "w1c_vs_set");

    // Soft reset with nonzero mask and flags. Afterwards the held switches
    // are debounced again and set their flags.
    writeReg(A_MASK, 32'hFFFF);
    idle(1);
    checkOutput("irq_all_mask", {31'd0, interrupt_request_o}, 32'd1);
    writeReg(A_RESET, 32'h1);
    checkOutput("soft_rst_irq", {31'd0, interrupt_request_o}, 32'd0);
    applyStimulus(A_MASK,  32'h0, "soft_rst_mask");
    applyStimulus(A_FLAGS, 32'h0, "soft_rst_flags");
    applyStimulus(A_VALUE, 32'h0, "soft_rst_value");
    idle(5);
    applyStimulus(A_VALUE, 32'hA5, "redebounce_value");
    applyStimulus(A_FLAGS, 32'hA5, "redebounce_flags");

    // Unmapped and read-only offsets.
    applyStimulus(32'h10, 32'h0, "unmapped_read");
    applyStimulus(A_RESET, 32'h0, "reset_reg_read");
    writeReg(A_VALUE, 32'hFFFF);
    applyStimulus(A_VALUE, 32'hA5, "value_ro");

    // RD_o holds across idle and write cycles.
    idle(2);
    checkOutput("rd_hold_idle", RD_o, 32'hA5);
    writeReg(32'h10, 32'h1234);
    checkOutput("rd_hold_write", RD_o, 32'hA5);

    // Edge-select register and its effect on a falling transition.
    writeReg(A_EDGE, 32'h0001);
    writeReg(A_FLAGS, 32'hFFFF);
    sw_i = 16'h00A4;
    idle(8);
`ifdef SW_SB_EDGE_SEL_EN
    applyStimulus(A_EDGE,  32'h1, "edge_reg");
    applyStimulus(A_FLAGS, 32'h0, "edge_fall_ignored");
`else
    applyStimulus(A_EDGE,  32'h0, "edge_reg_absent");
    applyStimulus(A_FLAGS, 32'h1, "fall_sets_flag");
`endif

    // Hard reset beats a simultaneous bus write.
    rst_i = 1'b1;
    writeReg(A_MASK, 32'hFFFF);
    rst_i = 1'b0;
    applyStimulus(A_MASK, 32'h0, "rst_priority_mask");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule

// File: doc/sw_debounce_sb_ctrl.md
Name: sw_debounce_sb_ctrl

Overview:
Parametrised switch-input peripheral on the system bus, successor to the plain combinational switch reader.
- Synchronises and debounces SW_WIDTH switch inputs.
- Latches per-bit change flags and raises a maskable interrupt request with a return handshake.
- Returns registered read data on the bus.
- Sits beside the other *_sb_ctrl peripherals behind the system-bus address decoder.

Parameters:
SW_WIDTH, 16, number of switch channels; legal 1..32.
DEBOUNCE_CYCLES, 1000, consecutive clk_i cycles a synchronised input must differ from the stable value before the stable value updates; legal >= 2.

Ports:
clk_i  input  1  system clock; all logic is on its rising edge.
rst_i  input  1  synchronous, active-high reset.
req_i  input  1  bus request, qualified by the decoder for this peripheral.
WE_i  input  1  1 = write, 0 = read; valid when req_i = 1.
addr_i  input  32  byte address; only addr_i[7:0] is decoded.
WD_i  input  32  write data.
RD_o  output  32  registered read data.
sw_i  input  SW_WIDTH  raw asynchronous switch levels.
interrupt_request_o  output  1  level interrupt request.
interrupt_return_i  input  1  one-cycle pulse from the interrupt controller when the handler returns.

Behaviour:
- Reset (rst_i = 1, or a soft reset) on the next clock edge:
  - RD_o = 0, interrupt_request_o = 0.
  - stable = 0, flags = 0, mask = 0.
  - All debounce counters = 0, synchroniser flops = 0.
- Synchroniser: two flops per bit, so 2 cycles of latency into the debouncer.
- Debounce, per bit, with counter width $clog2(DEBOUNCE_CYCLES):
  - If sync bit == stable bit, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the input still differs, the stable bit toggles on that edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches stable.
  - Total latency from a sw_i change to stable = 2 + DEBOUNCE_CYCLES cycles.
- Change flags: flags[i] sets on the cycle stable[i] toggles, in either direction.
- Register map (offset = addr_i[7:0]):
  - 0x00 VALUE: RO, stable zero-extended to 32 bits.
  - 0x04 FLAGS: read returns flags; write-1-to-clear with WD_i[SW_WIDTH-1:0].
  - 0x08 MASK: RW, SW_WIDTH bits.
  - 0x24 RESET: write of WD_i == 1 performs a soft reset identical to rst_i. Reads return 0.
  - Any other offset: reads return 0, writes are ignored.
- Read timing: on req_i && !WE_i, RD_o loads the selected value on the next edge and holds until the next read. RD_o is unchanged during writes and idle cycles.
- Write timing: on req_i && WE_i, the write takes effect on the next edge.
- Interrupt:
  - interrupt_request_o is registered as |(flags & mask) from the previous cycle, giving 1 cycle of latency.
  - interrupt_return_i clears all flags whose mask bit is 1.
- Simultaneous events:
  - A flag set in the same cycle as a W1C or interrupt_return_i clear: set wins.
  - A MASK write and a return in the same cycle: the return uses the old mask.
- Read of FLAGS in the same cycle as a flag set returns the pre-update value.
- rst_i has priority over every bus access and over interrupt_return_i.
- Reset during a debounce count discards the partial count.
- Switches held at 1 through reset are re-debounced: stable goes to 1 after 2 + DEBOUNCE_CYCLES cycles and sets the flag.

Optional Feature:
SW_SB_EDGE_SEL_EN
- Defined: adds register 0x0C EDGE (RW, SW_WIDTH bits, reset 0), which selects which transitions of stable[i] set flags[i]:
  - EDGE[i] = 1: only rising transitions (0->1).
  - EDGE[i] = 0: both directions.
- Not defined: offset 0x0C reads 0 and ignores writes; every transition sets its flag.

Test Plan:
- Bench uses SW_WIDTH=16, DEBOUNCE_CYCLES=4.
- Reset then read 0x00 -> RD_o = 0 one cycle after the request; interrupt_request_o = 0.
- sw_i = 0x00A5 held -> VALUE reads 0x00A5 exactly 6 cycles after the change, not at 5; FLAGS = 0x00A5.
- sw_i[0] pulses high for 3 cycles -> VALUE[0] and FLAGS[0] stay 0.
- MASK = 0x0001, sw_i[0] 0->1 -> interrupt_request_o rises 1 cycle after FLAGS[0] sets. A one-cycle interrupt_return_i pulse -> FLAGS[0] = 0 and the request drops 1 cycle later. FLAGS bits outside the mask are unaffected.
- W1C of 0x0004 to FLAGS in the same cycle bit 2 sets -> FLAGS[2] remains 1.
- Write 1 to 0x24 with MASK = 0xFFFF and FLAGS nonzero -> the next cycle reads MASK = 0 and FLAGS = 0.
- Read of 0x10 -> RD_o = 0.
- With SW_SB_EDGE_SEL_EN: EDGE = 0x0001, sw_i[0] 1->0 -> FLAGS[0] stays 0.
